// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: frame decoder for the UART receive byte stream.
// Frame format: SYNC, CMD, LEN, LEN payload bytes, CHK (XOR of CMD, LEN, payload).
// Good frames are copied into a held output buffer. Length, checksum and timeout
// errors are reported as 1-cycle pulses.
module uart_cmd_parser #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
    parameter int unsigned MAX_LEN        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    output logic       frame_valid_o,
    output logic [7:0] frame_cmd_o,
    output logic [3:0] frame_len_o,
    input  logic [3:0] payload_rd_addr_i,
    output logic [7:0] payload_rd_data_o,
    output logic       err_checksum_o,
    output logic       err_length_o,
    output logic       err_timeout_o,
    output logic       busy_o
);

    localparam int unsigned IdxW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned BufDepth = 1 << IdxW;
    localparam int unsigned TmoW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      MaxLenB = 8'(MAX_LEN);
    localparam logic [3:0]      MaxLenN = 4'(MAX_LEN);

    typedef enum logic [2:0] {StIdle, StCmd, StLen, StPayload, StChk} state_e;

    state_e          state_q, state_d;
    logic [7:0]      acc_q, acc_d;
    logic [7:0]      work_cmd_q, work_cmd_d;
    logic [3:0]      work_len_q, work_len_d;
    logic [3:0]      idx_q, idx_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      wbuf_q [BufDepth];
    logic [7:0]      wbuf_d [BufDepth];
    logic [7:0]      obuf_q [BufDepth];
    logic [7:0]      obuf_d [BufDepth];
    logic [7:0]      frame_cmd_q, frame_cmd_d;
    logic [3:0]      frame_len_q, frame_len_d;
    logic            fv_q, fv_d;
    logic            ec_q, ec_d;
    logic            el_q, el_d;
    logic            et_q, et_d;

    // Next-state: frame walk, checksum accumulation, timeout and result pulses.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        work_cmd_d  = work_cmd_q;
        work_len_d  = work_len_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        wbuf_d      = wbuf_q;
        obuf_d      = obuf_q;
        frame_cmd_d = frame_cmd_q;
        frame_len_d = frame_len_q;
        fv_d        = 1'b0;
        ec_d        = 1'b0;
        el_d        = 1'b0;
        et_d        = 1'b0;

        if (state_q == StIdle) begin
            tmo_d = '0;
            if (rx_valid_i && (rx_byte_i == SYNC_BYTE)) begin
                state_d = StCmd;
                acc_d   = 8'h00;
            end
        end else if (rx_valid_i) begin
            // A byte arriving on the expiry cycle takes priority over the timeout.
            tmo_d = '0;
            case (state_q)
                StCmd: begin
                    work_cmd_d = rx_byte_i;
                    acc_d      = acc_q ^ rx_byte_i;
                    state_d    = StLen;
                end
                StLen: begin
                    acc_d      = acc_q ^ rx_byte_i;
                    idx_d      = 4'd0;
                    work_len_d = rx_byte_i[3:0];
                    if (rx_byte_i > MaxLenB) begin
                        el_d    = 1'b1;
                        state_d = StIdle;
                    end else if (rx_byte_i == 8'h00) begin
                        state_d = StChk;
                    end else begin
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    wbuf_d[idx_q[IdxW-1:0]] = rx_byte_i;
                    acc_d = acc_q ^ rx_byte_i;
                    idx_d = idx_q + 4'd1;
                    if ((idx_q + 4'd1) == work_len_q) begin
                        state_d = StChk;
                    end
                end
                StChk: begin
                    if (rx_byte_i == acc_q) begin
                        fv_d        = 1'b1;
                        frame_cmd_d = work_cmd_q;
                        frame_len_d = work_len_q;
                        obuf_d      = wbuf_q;
                    end else begin
                        ec_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end else if (tmo_q == TmoLast) begin
            et_d    = 1'b1;
            tmo_d   = '0;
            state_d = StIdle;
        end else begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            acc_q       <= 8'h00;
            work_cmd_q  <= 8'h00;
            work_len_q  <= 4'd0;
            idx_q       <= 4'd0;
            tmo_q       <= '0;
            frame_cmd_q <= 8'h00;
            frame_len_q <= 4'd0;
            fv_q        <= 1'b0;
            ec_q        <= 1'b0;
            el_q        <= 1'b0;
            et_q        <= 1'b0;
            for (int unsigned i = 0; i < BufDepth; i++) begin
                wbuf_q[i] <= 8'h00;
                obuf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            work_cmd_q  <= work_cmd_d;
            work_len_q  <= work_len_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            frame_cmd_q <= frame_cmd_d;
            frame_len_q <= frame_len_d;
            fv_q        <= fv_d;
            ec_q        <= ec_d;
            el_q        <= el_d;
            et_q        <= et_d;
            wbuf_q      <= wbuf_d;
            obuf_q      <= obuf_d;
        end
    end

    // Combinational payload read; addresses beyond the buffer read as zero.
    always_comb begin
        payload_rd_data_o = 8'h00;
        if (payload_rd_addr_i < MaxLenN) begin
            payload_rd_data_o = obuf_q[payload_rd_addr_i[IdxW-1:0]];
        end
    end

    assign frame_valid_o  = fv_q;
    assign err_checksum_o = ec_q;
    assign err_length_o   = el_q;
    assign err_timeout_o  = et_q;
    assign frame_cmd_o    = frame_cmd_q;
    assign frame_len_o    = frame_len_q;
    assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and random frames against a frame-level reference model.
module tb_uart_cmd_parser;

    localparam int unsigned MaxLen = 8;
    localparam int unsigned Tmo    = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       frame_valid;
    logic [7:0] frame_cmd;
    logic [3:0] frame_len;
    logic [3:0] payload_rd_addr;
    logic [7:0] payload_rd_data;
    logic       err_checksum;
    logic       err_length;
    logic       err_timeout;
    logic       busy;
    logic [3:0] pulse_v;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the last good frame.
    logic [7:0] m_cmd;
    logic [3:0] m_len;
    logic [7:0] m_pay [16];

    uart_cmd_parser #(
        .SYNC_BYTE      (8'hAA),
        .MAX_LEN        (MaxLen),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .rx_byte_i         (rx_byte),
        .rx_valid_i        (rx_valid),
        .frame_valid_o     (frame_valid),
        .frame_cmd_o       (frame_cmd),
        .frame_len_o       (frame_len),
        .payload_rd_addr_i (payload_rd_addr),
        .payload_rd_data_o (payload_rd_data),
        .err_checksum_o    (err_checksum),
        .err_length_o      (err_length),
        .err_timeout_o     (err_timeout),
        .busy_o            (busy)
    );

    always #10 clk = ~clk;

    assign pulse_v = {frame_valid, err_checksum, err_length, err_timeout};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic model_clear();
        m_cmd = 8'h00;
        m_len = 4'd0;
        for (int i = 0; i < 16; i++) m_pay[i] = 8'h00;
    endtask

    task automatic check_held(input string tag);
        check({tag, ".cmd"}, frame_cmd, m_cmd);
        check({tag, ".len"}, frame_len, m_len);
        for (int i = 0; i < int'(m_len); i++) begin
            payload_rd_addr = 4'(i);
            #1;
            check($sformatf("%s.pay%0d", tag, i), payload_rd_data, m_pay[i]);
        end
    endtask

    // Expected outcome of a frame starting at SYNC: {valid, chk_err, len_err, tmo_err}.
    function automatic logic [3:0] expect_frame(input logic [7:0] f[$]);
        logic [7:0] x;
        int         len;
        len = int'(f[2]);
        if (len > int'(MaxLen)) return 4'b0010;
        x = 8'h00;
        for (int i = 1; i <= 2 + len; i++) x ^= f[i];
        return (x == f[3 + len]) ? 4'b1000 : 4'b0100;
    endfunction

    task automatic run_frame(input string tag, input logic [7:0] f[$], input int gap_max);
        logic [3:0] exp;
        logic [7:0] lb;
        int         last;
        exp  = expect_frame(f);
        last = f.size() - 1;
        for (int i = 0; i <= last; i++) begin
            send(f[i]);
            if (i == last) begin
                check({tag, ".pulse"}, pulse_v, exp);
                check({tag, ".idle"}, busy, 1'b0);
            end else begin
                check({tag, ".mid"}, pulse_v, 4'b0000);
                repeat ($urandom_range(gap_max, 0)) tick();
            end
        end
        if (exp == 4'b1000) begin
            m_cmd = f[1];
            lb    = f[2];
            m_len = lb[3:0];
            for (int j = 0; j < int'(m_len); j++) m_pay[j] = f[3 + j];
        end
        tick();
        check({tag, ".one"}, pulse_v, 4'b0000);
        check_held(tag);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] b;
        logic [7:0] x;
        int         len;

        rst             = 1'b1;
        rx_valid        = 1'b0;
        rx_byte         = 8'h00;
        payload_rd_addr = 4'd0;
        model_clear();
        repeat (2) tick();
        check("rst.pulse", pulse_v, 4'b0000);
        check("rst.busy", busy, 1'b0);
        check("rst.cmd", frame_cmd, 8'h00);
        check("rst.len", frame_len, 4'd0);
        check("rst.data", payload_rd_data, 8'h00);
        rst = 1'b0;
        tick();

        q = '{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        run_frame("c1", q, 2);

        q = '{8'hAA, 8'h05, 8'h00, 8'h05};
        run_frame("c2a", q, 1);
        q = '{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
        run_frame("c2b", q, 1);

        q = '{8'hAA, 8'h01, 8'h09};
        run_frame("c3a", q, 1);
        q = '{8'hAA, 8'h01, 8'h01, 8'h33, 8'h33};
        run_frame("c3b", q, 1);

        // Timeout: Tmo idle cycles after a byte inside a frame.
        send(8'hAA);
        send(8'h01);
        repeat (Tmo - 1) tick();
        check("c4.pre", pulse_v, 4'b0000);
        check("c4.busy", busy, 1'b1);
        tick();
        check("c4.tmo", pulse_v, 4'b0001);
        check("c4.idle", busy, 1'b0);
        tick();
        check("c4.one", pulse_v, 4'b0000);
        check_held("c4");
        // Byte on the expiry cycle keeps the frame alive.
        send(8'hAA);
        send(8'h01);
        repeat (Tmo - 1) tick();
        send(8'h00);
        check("c4b.edge", pulse_v, 4'b0000);
        check("c4b.busy", busy, 1'b1);
        send(8'h01);
        check("c4b.pulse", pulse_v, 4'b1000);
        m_cmd = 8'h01;
        m_len = 4'd0;
        tick();
        check_held("c4b");

        send(8'h00);
        send(8'hFF);
        send(8'h55);
        check("c5.junk", busy, 1'b0);
        q = '{8'hAA, 8'h7E, 8'h01, 8'hAA, 8'hD5};
        run_frame("c5", q, 1);

        q = '{8'hAA, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
        run_frame("c6", q, 0);

        // Reset in the middle of the payload.
        send(8'hAA);
        send(8'h10);
        send(8'h02);
        send(8'h11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        payload_rd_addr = 4'd0;
        #1;
        check("c6r.pulse", pulse_v, 4'b0000);
        check("c6r.busy", busy, 1'b0);
        check("c6r.data", payload_rd_data, 8'h00);
        check_held("c6r");
        tick();
        check("c6r.after", pulse_v, 4'b0000);

        // Random frames with junk prefix, random lengths and occasional bad checksum.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(2, 0)) begin
                b = 8'($urandom_range(255, 0));
                if (b == 8'hAA) b = 8'h00;
                send(b);
            end
            q   = {};
            q.push_back(8'hAA);
            b   = 8'($urandom_range(255, 0));
            q.push_back(b);
            len = int'($urandom_range(10, 0));
            q.push_back(8'(len));
            if (len <= int'(MaxLen)) begin
                x = b ^ 8'(len);
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom_range(255, 0));
                    q.push_back(b);
                    x ^= b;
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                q.push_back(x);
            end
            run_frame($sformatf("rnd%0d", n), q, 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
